decoder_pipe_hs: RTL
====================

// Module: decoder_pipe_hs
// PURPOSE
//  Registered, parametrised N-to-OUT_W code decoder with valid/ready handshake on both sides.
//  Runtime-selectable output mode: one-hot, thermometer or one-cold; out-of-range codes are flagged.
//  Two-entry skid buffer gives full throughput with a registered in_ready.
//  Sits between address/select generators and banked enables (memory banks, mux selects, channel gates).
// PARAMETERS
//  N      3       code width in bits
//  OUT_W  1<<N    decoded output width; legal range 1..(1<<N); codes >= OUT_W are out of range
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input code valid
//  in_ready   out  1      block can accept; registered
//  in_code    in   N      code to decode
//  in_mode    in   2      00 one-hot, 01 thermometer, 10 one-cold, 11 reserved
//  out_valid  out  1      out_data/out_err valid
//  out_ready  in   1      downstream accepts
//  out_data   out  OUT_W  decoded word
//  out_err    out  1      code out of range or mode reserved
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_err=0, in_ready=1, skid empty; applies immediately (async).
//  Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
//  Decode of code c, all rules applied to bits 0..OUT_W-1:
//   one-hot:     bit i = (i==c)
//   thermometer: bit i = (i<=c)
//   one-cold:    bitwise inverse of one-hot
//   c >= OUT_W:  out_data = all 0 (one-hot, thermometer) or all 1 (one-cold); out_err=1
//   mode 11:     out_data = 0, out_err=1
//  Comparison of c against OUT_W is unsigned, done at N+1 bits.
//  Latency: accepted code appears on out_data one cycle after acceptance (output register empty or draining).
//  Occupancy states: EMPTY (no entries), ONE (output reg valid), FULL (output reg + skid valid).
//   EMPTY: accept -> ONE.
//   ONE: accept & !drain -> FULL (new word to skid); accept & drain -> ONE (new word to output reg);
//        !accept & drain -> EMPTY.
//   FULL: in_ready=0; drain -> ONE (skid moves to output reg).
//  in_ready = (state != FULL), taken from registered state only; no combinational path from out_ready.
//  Order preserved: output reg always holds the oldest entry. No entry lost or duplicated.
//  out_data/out_err held stable while out_valid=1 and out_ready=0.
//  in_mode is sampled with in_code at acceptance; later mode changes do not affect stored entries.
//  Simultaneous accept and drain in ONE: throughput of 1 word/cycle.
//  in_valid while FULL is ignored; the source must hold it. in_code and in_mode are don't-care when in_valid=0.
//  Reset asserted mid-operation: all entries discarded, outputs return to reset values.
// STRUCTURE
//  Shared package decoder_pkg: mode localparams (DEC_ONEHOT, DEC_THERM, DEC_ONECOLD, DEC_RSVD)
//   and occupancy state encoding.
//  Sub-module decoder_core: purely combinational decode of (code, mode) -> (data, err),
//   parametrised by N and OUT_W.
//  Top level: handshake/skid control plus output and skid data registers.
// TESTING
//  1. N=3, OUT_W=8, mode 00, codes 0..7 back-to-back, out_ready=1 -> out_data 0x01..0x80, one per cycle,
//     1-cycle latency, in_ready stays 1.
//  2. Mode 01, code 5 -> 0x3F; mode 10, code 2 -> 0xFB; mode 11, code 2 -> 0x00 with out_err=1.
//  3. OUT_W=6, code 6 in one-hot -> 0x00, out_err=1; code 7 in one-cold -> 0x3F, out_err=1;
//     code 5 in thermometer -> 0x3F, out_err=0.
//  4. out_ready=0, then send codes 1,2,3 -> 1 and 2 accepted, in_ready=0 in the cycle after the second accept.
//     Release out_ready -> outputs 0x02, 0x04, 0x08 in order, data stable while stalled.
//  5. Random in_valid/out_ready, 10k transfers -> scoreboard matches the model exactly; no loss, duplication or reordering.
//  6. Assert rst while FULL -> out_valid=0, out_data=0, in_ready=1 with no clock edge needed;
//     first code after reset decodes correctly.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - decode modes and occupancy encoding shared by the decoder pipe
package decoder_pkg;

    localparam logic [1:0] DEC_ONEHOT  = 2'b00;
    localparam logic [1:0] DEC_THERM   = 2'b01;
    localparam logic [1:0] DEC_ONECOLD = 2'b10;
    localparam logic [1:0] DEC_RSVD    = 2'b11;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/decoder_core.sv
// rtl/decoder_core.sv - combinational code-to-word decode with range/mode error flag
module decoder_core
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int OUT_W = 1 << N
) (
    input  logic [N-1:0]     code,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data,
    output logic             err
);

    logic [N:0]       code_x;
    logic             in_range;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;

    // Widened by one bit so OUT_W == 1<<N is representable in the compare.
    assign code_x   = {1'b0, code};
    assign in_range = code_x < (N+1)'(OUT_W);

    always_comb begin
        onehot = '0;
        therm  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (code_x == (N+1)'(i));
            therm[i]  = in_range && ((N+1)'(i) <= code_x);
        end
    end

    always_comb begin
        data = '0;
        err  = !in_range;
        case (mode)
            DEC_ONEHOT:  data = onehot;
            DEC_THERM:   data = therm;
            DEC_ONECOLD: data = ~onehot;
            default: begin
                data = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decoder_pipe_hs.sv
// rtl/decoder_pipe_hs.sv - registered decoder with valid/ready handshake and two-entry skid
module decoder_pipe_hs
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int OUT_W = 1 << N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_code,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    logic [1:0]       state;
    logic [OUT_W-1:0] dec_data;
    logic             dec_err;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic             accept;
    logic             drain;

    decoder_core #(
        .N     (N),
        .OUT_W (OUT_W)
    ) u_core (
        .code (in_code),
        .mode (in_mode),
        .data (dec_data),
        .err  (dec_err)
    );

    // Both handshake outputs depend on the state register alone.
    assign in_ready  = (state != OCC_FULL);
    assign out_valid = (state != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OCC_EMPTY;
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_data <= dec_data;
                        out_err  <= dec_err;
                        state    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        out_data <= dec_data;
                        out_err  <= dec_err;
                    end else if (accept) begin
                        skid_data <= dec_data;
                        skid_err  <= dec_err;
                        state     <= OCC_FULL;
                    end else if (drain) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (drain) begin
                        out_data <= skid_data;
                        out_err  <= skid_err;
                        state    <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

endmodule
